// File: rtl/rv32_pkg.sv
// ============================================================================
// Module   : rv32_pkg
// Brief    : Shared constants, FSM state and fault-cause encodings for fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

  localparam logic [31:0] c_reset_pc  = 32'h0000_0000;
  localparam logic [31:0] c_instr_nop = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [1:0] c_fault_none     = 2'b00;
  localparam logic [1:0] c_fault_misalign = 2'b01;
  localparam logic [1:0] c_fault_timeout  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module   : pc_reg
// Brief    : 32-bit architectural PC register with load enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_pc_next,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetch stage: holds PC, fetches over valid/ready request and
//            valid response, presents instruction to decode until retire.
//            FETCH_PERF_CNT_EN enables fetch/stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = c_reset_pc,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next_in,
  input  logic        pc_update,
  output logic [31:0] pc_current,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam int                  c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_max  = c_tmo_w'(TIMEOUT_CYCLES);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

  fetch_state_t        r_state;
  logic                r_req_valid;
  logic                r_instr_valid;
  logic [31:0]         r_instr;
  logic [31:0]         r_instr_pc;
  logic                r_fetch_fault;
  logic [1:0]          r_fault_cause;
  logic [c_tmo_w-1:0]  r_tmo_cnt;
  logic                w_pc_load;
  logic                w_misaligned;

  assign w_misaligned = (pc_next_in[1:0] != 2'b00);
  assign w_pc_load    = (r_state == S_HOLD) && pc_update && !w_misaligned;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_pc_load),
    .i_pc_next (pc_next_in),
    .o_pc      (pc_current)
  );

  // Request valid comes up one cycle after reset release, so a handshake
  // needs the registered valid as well as ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= c_instr_nop;
      r_instr_pc    <= RESET_PC;
      r_fetch_fault <= 1'b0;
      r_fault_cause <= c_fault_none;
      r_tmo_cnt     <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (r_req_valid && imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
            r_tmo_cnt   <= '0;
          end else begin
            r_req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_instr       <= imem_rsp_data;
            r_instr_pc    <= pc_current;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end else begin
            if (r_tmo_cnt == c_tmo_last) begin
              r_state       <= S_FAULT;
              r_fetch_fault <= 1'b1;
              r_fault_cause <= c_fault_timeout;
            end
            if (r_tmo_cnt != c_tmo_max) begin
              r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
            end
          end
        end
        S_HOLD: begin
          if (pc_update) begin
            r_instr_valid <= 1'b0;
            if (w_misaligned) begin
              r_state       <= S_FAULT;
              r_fetch_fault <= 1'b1;
              r_fault_cause <= c_fault_misalign;
            end else begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          r_req_valid   <= 1'b0;
          r_instr_valid <= 1'b0;
          r_fetch_fault <= 1'b1;
        end
        default: begin
          r_state <= S_FAULT;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = pc_current;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign fetch_fault    = r_fetch_fault;
  assign fault_cause    = r_fault_cause;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= 32'h0;
      r_perf_stall <= 32'h0;
    end else begin
      if ((r_state == S_WAIT) && imem_rsp_valid) begin
        r_perf_fetch <= r_perf_fetch + 32'h1;
      end
      if (((r_state == S_REQ) && !imem_req_ready) ||
          ((r_state == S_WAIT) && !imem_rsp_valid)) begin
        r_perf_stall <= r_perf_stall + 32'h1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit (FETCH_PERF_CNT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_next_in;
  logic        pc_update;
  logic [31:0] pc_current;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_next_in     (pc_next_in),
    .pc_update      (pc_update),
    .pc_current     (pc_current),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault),
    .fault_cause    (fault_cause),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: is a fetch outstanding, is an instruction held,
  // how long have we waited, and has the unit died.
  logic [31:0] m_pc, m_instr, m_ipc, m_fetch, m_stall;
  logic        m_req, m_outstanding, m_iv, m_fault;
  logic [1:0]  m_cause;
  int          m_wait;

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP; m_ipc = RESET_PC;
    m_req = 1'b0; m_outstanding = 1'b0; m_iv = 1'b0;
    m_fault = 1'b0; m_cause = 2'b00; m_wait = 0;
    m_fetch = 32'h0; m_stall = 32'h0;
  endtask

  task automatic model_fault(input logic [1:0] cause);
    m_fault = 1'b1; m_cause = cause;
    m_iv = 1'b0; m_req = 1'b0; m_outstanding = 1'b0;
  endtask

  initial model_reset();
  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else if (m_fault) begin
      // dead until reset
    end else if (m_iv) begin
      if (pc_update) begin
        if (pc_next_in[1:0] != 2'b00) model_fault(2'b01);
        else begin
          m_pc = pc_next_in; m_iv = 1'b0; m_req = 1'b1;
        end
      end
    end else if (m_outstanding) begin
      if (imem_rsp_valid) begin
        m_instr = imem_rsp_data; m_ipc = m_pc; m_iv = 1'b1;
        m_outstanding = 1'b0; m_fetch = m_fetch + 32'h1;
      end else begin
        m_stall = m_stall + 32'h1;
        m_wait++;
        if (m_wait >= TIMEOUT) model_fault(2'b10);
      end
    end else begin
      if (!imem_req_ready) m_stall = m_stall + 32'h1;
      if (m_req && imem_req_ready) begin
        m_req = 1'b0; m_outstanding = 1'b1; m_wait = 0;
      end else begin
        m_req = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("pc_current",     pc_current,            m_pc);
    chk("imem_req_addr",  imem_req_addr,         m_pc);
    chk("imem_req_valid", 32'(imem_req_valid),   32'(m_req));
    chk("instr_valid",    32'(instr_valid),      32'(m_iv));
    chk("instr",          instr,                 m_instr);
    chk("instr_pc",       instr_pc,              m_ipc);
    chk("fetch_fault",    32'(fetch_fault),      32'(m_fault));
    chk("fault_cause",    32'(fault_cause),      32'(m_cause));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt,        m_fetch);
    chk("perf_stall_cnt", perf_stall_cnt,        m_stall);
`else
    chk("perf_fetch_cnt", perf_fetch_cnt,        32'h0);
    chk("perf_stall_cnt", perf_stall_cnt,        32'h0);
`endif
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid) return;
      cyc();
    end
    chk("wait_req_timeout", 32'(imem_req_valid), 32'h1);
  endtask

  // Handshake, then ngap silent wait cycles, then one response beat.
  task automatic do_fetch(input logic [31:0] data, input int ngap);
    wait_req();
    imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
    repeat (ngap) cyc();
    imem_rsp_valid = 1'b1; imem_rsp_data = data; cyc();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic retire(input logic [31:0] nxt);
    pc_next_in = nxt; pc_update = 1'b1; cyc(); pc_update = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc_next_in = 32'h0; pc_update = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    repeat (3) cyc();
    chk("rst_pc",       pc_current,            32'h0);
    chk("rst_instr",    instr,                 NOP);
    chk("rst_req",      32'(imem_req_valid),   32'h0);
    chk("rst_iv",       32'(instr_valid),      32'h0);
    rst_n = 1'b1;
    cyc();
    chk("t1_addr",      imem_req_addr,         32'h0);
    do_fetch(32'h0010_0093, 0);
    chk("t1_iv",        32'(instr_valid),      32'h1);
    chk("t1_instr",     instr,                 32'h0010_0093);
    chk("t1_ipc",       instr_pc,              32'h0);

    retire(32'h0000_0100);
    do_fetch(32'h1111_0013, 0);
    chk("t2_ipc100",    instr_pc,              32'h0000_0100);
    retire(32'h0000_0210);
    chk("t2_pc",        pc_current,            32'h0000_0210);
    chk("t2_addr",      imem_req_addr,         32'h0000_0210);
    chk("t2_req",       32'(imem_req_valid),   32'h1);
    imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
    pc_next_in = 32'h0000_0300; pc_update = 1'b1; cyc(); pc_update = 1'b0;
    chk("t2_wait_upd",  pc_current,            32'h0000_0210);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_0013; cyc(); imem_rsp_valid = 1'b0;
    chk("t2_instr",     instr,                 32'h2222_0013);

    retire(32'hFFFF_FFFC);
    do_fetch(32'h3333_0013, 2);
    chk("wrap_ipc",     instr_pc,              32'hFFFF_FFFC);
    retire(32'h0000_0000);
    chk("wrap_pc",      pc_current,            32'h0);
    do_fetch(32'h4444_0013, 1);

    retire(32'h0000_0104);
    for (int i = 0; i < 3; i++) begin
      chk("t3_req",  32'(imem_req_valid), 32'h1);
      chk("t3_addr", imem_req_addr,       32'h0000_0104);
      pc_next_in = 32'h0000_0500; pc_update = 1'b1;
      cyc();
    end
    pc_update = 1'b0;
    do_fetch(32'h5555_0013, 0);

    retire(32'h0000_1006);
    chk("t4_fault",     32'(fetch_fault),      32'h1);
    chk("t4_cause",     32'(fault_cause),      32'h1);
    chk("t4_pc",        pc_current,            32'h0000_0104);
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; pc_update = 1'b1; pc_next_in = 32'h8;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_req_off", 32'(imem_req_valid), 32'h0);
    end
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; pc_update = 1'b0;

    do_reset();
    do_fetch(32'h6666_0013, TIMEOUT);
    chk("t5_tmo_fault", 32'(fetch_fault),      32'h1);
    chk("t5_tmo_cause", 32'(fault_cause),      32'h2);
    do_reset();
    do_fetch(32'h7777_0013, TIMEOUT - 1);
    chk("t5_edge_ok",   32'(fetch_fault),      32'h0);
    chk("t5_edge_ins",  instr,                 32'h7777_0013);

    do_reset();
    wait_req();
    imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    rst_n = 1'b0; repeat (2) cyc(); rst_n = 1'b1;
    cyc();
    imem_rsp_valid = 1'b0;
    chk("t6_instr",     instr,                 NOP);
    chk("t6_iv",        32'(instr_valid),      32'h0);
    chk("t6_req",       32'(imem_req_valid),   32'h1);
    chk("t6_addr",      imem_req_addr,         RESET_PC);
    do_fetch(32'h0020_0113, 0);
    chk("t6_new",       instr,                 32'h0020_0113);
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
